// File: rtl/hazard_forward_ctrl.sv
// Hazard detection, branch flush and operand forwarding control.
// Define FORWARDING_UNIT_EN to build the forwarding unit.
module hazard_forward_ctrl #(
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_use_src1,
    input  logic                  id_use_src2,
    input  logic [REG_ADDR_W-1:0] exe_src1,
    input  logic [REG_ADDR_W-1:0] exe_src2,
    input  logic [REG_ADDR_W-1:0] exe_dest,
    input  logic                  exe_wb_en,
    input  logic                  exe_mem_r_en,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  mem_wb_en,
    input  logic [REG_ADDR_W-1:0] wb_dest,
    input  logic                  wb_wb_en,
    input  logic                  branch_taken,
    output logic [1:0]            sel_src1,
    output logic [1:0]            sel_src2,
    output logic                  hazard,
    output logic                  flush,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam logic [REG_ADDR_W-1:0] R15 = REG_ADDR_W'(15);

    typedef enum logic {
        RUN          = 1'b0,
        FLUSH_SHADOW = 1'b1
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic       live1;
    logic       live2;
    logic       exe_hit;
    logic       raw_hazard;
    logic [1:0] fwd1;
    logic [1:0] fwd2;

    // Unused sources are masked before any compare so X never leaks.
    assign live1 = id_use_src1 & (id_src1 != R15);
    assign live2 = id_use_src2 & (id_src2 != R15);

    assign exe_hit = exe_wb_en
                   & ((live1 & (id_src1 == exe_dest))
                   |  (live2 & (id_src2 == exe_dest)));

`ifdef FORWARDING_UNIT_EN
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] src,
        input logic [REG_ADDR_W-1:0] m_dest,
        input logic                  m_wb,
        input logic [REG_ADDR_W-1:0] w_dest,
        input logic                  w_wb
    );
        logic [1:0] s;
        s = 2'b00;
        if (src == R15)
            s = 2'b00;
        else if (m_wb && (m_dest == src))
            s = 2'b01;
        else if (w_wb && (w_dest == src))
            s = 2'b10;
        return s;
    endfunction

    assign fwd1 = fwd_sel(exe_src1, mem_dest, mem_wb_en,
                          wb_dest, wb_wb_en);
    assign fwd2 = fwd_sel(exe_src2, mem_dest, mem_wb_en,
                          wb_dest, wb_wb_en);

    assign raw_hazard = exe_hit & exe_mem_r_en;
`else
    logic mem_hit;
    logic unused_nofwd;

    assign mem_hit = mem_wb_en
                   & ((live1 & (id_src1 == mem_dest))
                   |  (live2 & (id_src2 == mem_dest)));

    assign fwd1       = 2'b00;
    assign fwd2       = 2'b00;
    assign raw_hazard = exe_hit | mem_hit;

    assign unused_nofwd = ^{exe_src1, exe_src2, exe_mem_r_en,
                            wb_dest, wb_wb_en};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= RUN;
        else
            state_q <= state_d;
    end

    // Outputs are forced idle while reset is held.
    always_comb begin
        state_d  = state_q;
        hazard   = 1'b0;
        flush    = 1'b0;
        sel_src1 = 2'b00;
        sel_src2 = 2'b00;
        if (rst) begin
            flush    = branch_taken;
            sel_src1 = fwd1;
            sel_src2 = fwd2;
            unique case (state_q)
                RUN: begin
                    hazard  = raw_hazard & ~branch_taken;
                    state_d = branch_taken ? FLUSH_SHADOW : RUN;
                end
                FLUSH_SHADOW: begin
                    state_d = branch_taken ? FLUSH_SHADOW : RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (hazard && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl, both build flavours.
// Expected values depend on FORWARDING_UNIT_EN.
module tb_hazard_forward_ctrl;

`ifdef FORWARDING_UNIT_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] id_src1, id_src2, exe_src1, exe_src2, exe_dest;
    logic [3:0] mem_dest, wb_dest;
    logic       id_use_src1, id_use_src2, exe_wb_en, exe_mem_r_en;
    logic       mem_wb_en, wb_wb_en, branch_taken;
    logic [1:0] sel_src1, sel_src2, s_sel1, s_sel2;
    logic       hazard, flush, s_hazard, s_flush;
    logic [15:0] stall_cnt, flush_cnt;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_forward_ctrl #(.REG_ADDR_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src1(id_use_src1), .id_use_src2(id_use_src2),
        .exe_src1(exe_src1), .exe_src2(exe_src2),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
        .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .wb_dest(wb_dest), .wb_wb_en(wb_wb_en),
        .branch_taken(branch_taken),
        .sel_src1(sel_src1), .sel_src2(sel_src2),
        .hazard(hazard), .flush(flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_forward_ctrl #(.REG_ADDR_W(4), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src1(id_use_src1), .id_use_src2(id_use_src2),
        .exe_src1(exe_src1), .exe_src2(exe_src2),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
        .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .wb_dest(wb_dest), .wb_wb_en(wb_wb_en),
        .branch_taken(branch_taken),
        .sel_src1(s_sel1), .sel_src2(s_sel2),
        .hazard(s_hazard), .flush(s_flush),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    typedef struct {
        string      nm;
        logic [3:0] is1, is2;
        logic       u1, u2;
        logic [3:0] es1, es2, ed;
        logic       ewb, erd;
        logic [3:0] md;
        logic       mwb;
        logic [3:0] wd;
        logic       wwb;
        logic [1:0] s1f, s2f;
        logic       hf, hn;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        string nm,
        logic [3:0] is1, logic [3:0] is2, logic u1, logic u2,
        logic [3:0] es1, logic [3:0] es2, logic [3:0] ed,
        logic ewb, logic erd,
        logic [3:0] md, logic mwb, logic [3:0] wd, logic wwb,
        logic [1:0] s1f, logic [1:0] s2f, logic hf, logic hn
    );
        vec_t v;
        v.nm = nm;
        v.is1 = is1; v.is2 = is2; v.u1 = u1; v.u2 = u2;
        v.es1 = es1; v.es2 = es2; v.ed = ed;
        v.ewb = ewb; v.erd = erd;
        v.md = md; v.mwb = mwb; v.wd = wd; v.wwb = wwb;
        v.s1f = s1f; v.s2f = s2f; v.hf = hf; v.hn = hn;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic clear_in();
        id_src1 = 0; id_src2 = 0; id_use_src1 = 0; id_use_src2 = 0;
        exe_src1 = 0; exe_src2 = 0; exe_dest = 0;
        exe_wb_en = 0; exe_mem_r_en = 0;
        mem_dest = 0; mem_wb_en = 0; wb_dest = 0; wb_wb_en = 0;
        branch_taken = 0;
    endtask

    task automatic load_use();
        exe_dest = 4'd5; exe_wb_en = 1; exe_mem_r_en = 1;
        id_src2 = 4'd5; id_use_src2 = 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_in();
        rst = 0;
        @(negedge clk);
        rst = 1;
    endtask

    task automatic apply(vec_t v);
        id_src1 = v.is1; id_src2 = v.is2;
        id_use_src1 = v.u1; id_use_src2 = v.u2;
        exe_src1 = v.es1; exe_src2 = v.es2; exe_dest = v.ed;
        exe_wb_en = v.ewb; exe_mem_r_en = v.erd;
        mem_dest = v.md; mem_wb_en = v.mwb;
        wb_dest = v.wd; wb_wb_en = v.wwb;
        branch_taken = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //           nm     is1 is2 u1 u2 es1 es2 ed ewb erd md mwb wd wwb s1 s2 hf hn
        vecs.push_back(mk("idle",  0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("memwb", 0, 0, 0, 0,  3, 0, 0, 0, 0,  3, 1,  3, 1, 1, 0, 0, 0));
        vecs.push_back(mk("wbonly",0, 0, 0, 0,  3, 0, 0, 0, 0,  3, 0,  3, 1, 2, 0, 0, 0));
        vecs.push_back(mk("r15",   0, 0, 0, 0, 15, 0, 0, 0, 0, 15, 1, 15, 1, 0, 0, 0, 0));
        vecs.push_back(mk("both7", 0, 0, 0, 0,  7, 7, 0, 0, 0,  7, 1,  7, 1, 1, 1, 0, 0));
        vecs.push_back(mk("split", 0, 0, 0, 0,  4, 6, 0, 0, 0,  6, 1,  4, 1, 2, 1, 0, 0));
        vecs.push_back(mk("lu_s1", 5, 0, 1, 0,  0, 0, 5, 1, 1,  0, 0,  0, 0, 0, 0, 1, 1));
        vecs.push_back(mk("lu_off",5, 0, 0, 0,  0, 0, 5, 1, 1,  0, 0,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("lu_r15",15,0, 1, 0,  0, 0,15, 1, 1,  0, 0,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("alu_ex",0, 9, 0, 1,  0, 0, 9, 1, 0,  0, 0,  0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("no_wb", 0, 9, 0, 1,  0, 0, 9, 0, 1,  0, 0,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("mem_id",2, 0, 1, 0,  0, 0, 0, 0, 0,  2, 1,  0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("mem_off",2,0, 1, 0,  0, 0, 0, 0, 0,  2, 0,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("x_src", 4'bx, 0, 0, 0, 0, 0, 3, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0));

        // reset holds outputs idle
        clear_in();
        rst = 0;
        load_use();
        branch_taken = 1; exe_src1 = 3; mem_dest = 3; mem_wb_en = 1;
        #7;
        chk("rst_hazard", hazard, 0);
        chk("rst_flush", flush, 0);
        chk("rst_sel1", sel_src1, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_fcnt", flush_cnt, 0);
        @(negedge clk);
        clear_in();
        rst = 1;

        foreach (vecs[i]) begin
            @(negedge clk);
            apply(vecs[i]);
            #1;
            chk({vecs[i].nm, "_sel1"}, sel_src1, FWD ? vecs[i].s1f : 2'b00);
            chk({vecs[i].nm, "_sel2"}, sel_src2, FWD ? vecs[i].s2f : 2'b00);
            chk({vecs[i].nm, "_haz"}, hazard, FWD ? vecs[i].hf : vecs[i].hn);
            chk({vecs[i].nm, "_flush"}, flush, 0);
        end

        // load-use stall and counter step
        do_reset();
        load_use();
        #1 chk("lu_haz", hazard, 1);
        @(negedge clk);
        chk("lu_cnt", stall_cnt, 1);
        exe_mem_r_en = 0;
        #1 chk("lu_norl", hazard, FWD ? 0 : 1);

        // branch beats stall, shadow cycle, then stall
        do_reset();
        load_use();
        branch_taken = 1;
        #1;
        chk("br_flush", flush, 1);
        chk("br_haz", hazard, 0);
        @(negedge clk);
        chk("br_fcnt", flush_cnt, 1);
        chk("br_scnt", stall_cnt, 0);
        branch_taken = 0;
        #1;
        chk("sh_haz", hazard, 0);
        chk("sh_flush", flush, 0);
        @(negedge clk);
        chk("sh_scnt", stall_cnt, 0);
        chk("run_haz", hazard, 1);
        @(negedge clk);
        chk("run_scnt", stall_cnt, 1);

        // branch while in shadow keeps the shadow
        do_reset();
        load_use();
        branch_taken = 1;
        @(negedge clk);
        #1 chk("bb_flush", flush, 1);
        @(negedge clk);
        branch_taken = 0;
        #1 chk("bb_haz", hazard, 0);
        chk("bb_fcnt", flush_cnt, 2);

        // saturation
        do_reset();
        load_use();
        repeat (20) @(negedge clk);
        chk("sat_small", s_stall_cnt, 15);
        chk("sat_big", stall_cnt, 20);

        // async reset mid-shadow
        do_reset();
        load_use();
        repeat (7) @(negedge clk);
        branch_taken = 1;
        repeat (7) @(negedge clk);
        branch_taken = 0;
        chk("pre_scnt", stall_cnt, 7);
        chk("pre_fcnt", flush_cnt, 7);
        #1 chk("pre_shadow", hazard, 0);
        #1 rst = 0;
        #1;
        chk("ar_scnt", stall_cnt, 0);
        chk("ar_fcnt", flush_cnt, 0);
        chk("ar_haz", hazard, 0);
        @(negedge clk);
        rst = 1;
        #1 chk("ar_run", hazard, 1);
        @(negedge clk);
        chk("ar_first", stall_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_forward_ctrl.md
HAZARD_FORWARD_CTRL -- requirements
Module: hazard_forward_ctrl

Interface
REQ-001 SHALL have parameters: REG_ADDR_W, default 4, register-address width; CNT_W, default 16, width of the performance counters.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_src1, id_src2  in  REG_ADDR_W  source registers of the instruction in ID.
- id_use_src1, id_use_src2  in  1  the ID instruction reads that source.
- exe_src1, exe_src2  in  REG_ADDR_W  sources of the instruction in EXE.
- exe_dest  in  REG_ADDR_W  destination of the instruction in EXE.
- exe_wb_en, exe_mem_r_en  in  1  writeback enable and load flag of the instruction in EXE.
- mem_dest, mem_wb_en  in  REG_ADDR_W / 1  destination and writeback enable of the instruction in MEM.
- wb_dest, wb_wb_en  in  REG_ADDR_W / 1  destination and writeback enable of the instruction in WB.
- branch_taken  in  1  branch resolved taken in EXE.
- sel_src1, sel_src2  out  2  EXE ALU operand selects: 00 register value, 01 mem_wb_val, 10 wb_wb_val.
- hazard  out  1  freezes PC and the IF/ID register and injects a bubble into ID/EXE.
- flush  out  1  clears the IF/ID and ID/EXE registers.
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters.

Function
REQ-003 SHALL implement FSM states RUN and FLUSH_SHADOW, encoded 0 and 1.
REQ-004 In any state, branch_taken=1 SHALL drive flush=1 combinationally in the same cycle, force hazard=0, and move the FSM to FLUSH_SHADOW on the next edge.
REQ-005 FLUSH_SHADOW SHALL last exactly one cycle and return to RUN unless branch_taken=1. In FLUSH_SHADOW, hazard=0, because the ID contents are a bubble.
REQ-006 A source is "live" when its id_use_srcN=1 and it is not register 15.
REQ-007 With forwarding compiled in: in RUN with branch_taken=0, hazard SHALL be 1 iff exe_wb_en & exe_mem_r_en and exe_dest equals any live ID source (load-use).
REQ-008 Forwarding select for each exe_srcN, evaluated combinationally:
- if mem_wb_en and mem_dest==exe_srcN, then 01;
- else if wb_wb_en and wb_dest==exe_srcN, then 10;
- else 00.
- exe_srcN==15 SHALL always give 00.
- MEM SHALL take priority over WB when both match.
REQ-009 sel_src1, sel_src2, hazard and flush SHALL be combinational, with zero latency.
REQ-010 stall_cnt SHALL increment on each edge where hazard=1 and saturate at all-ones.
REQ-011 flush_cnt SHALL increment on each edge where flush=1 and saturate at all-ones.
REQ-012 A branch_taken arriving simultaneously with a load-use match SHALL give flush=1, hazard=0, and stall_cnt unchanged.
REQ-013 X or out-of-range values on unused sources (id_use_srcN=0) SHALL NOT affect hazard.

Reset
REQ-014 rst=0 SHALL asynchronously set the FSM to RUN and clear stall_cnt and flush_cnt to 0.
REQ-015 While rst=0, the block SHALL hold hazard=0, flush=0, sel_src1=00 and sel_src2=00, regardless of inputs.
REQ-016 Deassertion of rst SHALL take effect on the next rising clk. Reset asserted mid-FLUSH_SHADOW SHALL return the FSM to RUN.

Configuration
REQ-017 Macro FORWARDING_UNIT_EN, when defined, SHALL compile in the forwarding behaviour of REQ-007 and REQ-008.
REQ-018 Without FORWARDING_UNIT_EN:
- sel_src1 and sel_src2 SHALL be constant 00.
- In RUN, hazard SHALL be 1 iff a live ID source equals exe_dest with exe_wb_en=1, or equals mem_dest with mem_wb_en=1 (load or not).
- Branch and FSM rules SHALL be unchanged.

Verification
REQ-019 Forwarding priority (FORWARDING_UNIT_EN): exe_src1=3, mem_dest=3, mem_wb_en=1, wb_dest=3, wb_wb_en=1 -> sel_src1=01; then mem_wb_en=0 -> sel_src1=10; then exe_src1=15 -> sel_src1=00.
REQ-020 Load-use stall: exe_dest=5, exe_wb_en=1, exe_mem_r_en=1, id_src2=5, id_use_src2=1, held 1 cycle -> hazard=1, stall_cnt 0->1; then exe_mem_r_en=0 -> hazard=0.
REQ-021 Branch vs stall: branch_taken=1 with the REQ-020 load-use condition -> flush=1, hazard=0, flush_cnt +1, stall_cnt unchanged; next cycle with the same load-use inputs -> FSM in FLUSH_SHADOW, hazard=0; following cycle -> hazard=1.
REQ-022 Saturation: CNT_W=4, load-use hazard held 20 cycles -> stall_cnt stops at 15.
REQ-023 Async reset: rst=0 asserted mid-cycle while in FLUSH_SHADOW with counters at 7 -> counters read 0 immediately; the first edge after release is in RUN.
REQ-024 No-forwarding build (macro undefined): mem_dest=2, mem_wb_en=1, id_src1=2, id_use_src1=1 -> hazard=1, sel_src1=00.
